// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative divider.
//   DIV_WIDTH       : default operand/result width
//   DIV_CNT_W       : step counter width, clog2(WIDTH+1)
//   DIV_ITER_CYCLES : restoring steps per division (one quotient bit each)
//   state_t         : control FSM encoding
package div_pkg;

    localparam int unsigned DIV_WIDTH       = 32;
    localparam int unsigned DIV_CNT_W       = $clog2(DIV_WIDTH + 1);
    localparam int unsigned DIV_ITER_CYCLES = DIV_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_FIX  = 3'd2,
        S_DONE = 3'd3,
        S_HOLD = 3'd4
    } state_t;

endpackage

// File: rtl/divide_if.sv
// Request/result bundle between a requester and the divider.
//   master : drives div_begin, div_signed, div_op1, div_op2; receives results
//   slave  : the divider side
//   div_begin is level-held by the requester until div_end is seen.
interface divide_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) ();

    logic             div_begin;
    logic             div_signed;
    logic [WIDTH-1:0] div_op1;
    logic [WIDTH-1:0] div_op2;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             div_end;

    modport master (
        output div_begin, div_signed, div_op1, div_op2,
        input  quotient, remainder, div_by_zero, div_end
    );

    modport slave (
        input  div_begin, div_signed, div_op1, div_op2,
        output quotient, remainder, div_by_zero, div_end
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   rem      : partial remainder, always < divisor on entry
//   bit_in   : next dividend bit shifted into the remainder
//   divisor  : unsigned divisor magnitude
//   rem_next : updated partial remainder
//   q_bit    : quotient bit produced by this step
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // Extra top bit of trial acts as the borrow: set means shifted < divisor.
    always_comb begin
        shifted  = {rem, bit_in};
        trial    = {1'b0, shifted} - {2'b00, divisor};
        q_bit    = ~trial[WIDTH+1];
        // Both candidates fit in WIDTH bits because rem < divisor on entry.
        rem_next = q_bit ? WIDTH'(trial) : WIDTH'(shifted);
    end

endmodule

// File: rtl/divide.sv
// Iterative restoring divider, signed/unsigned, fixed latency.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : divide_if slave (begin/signed/operands in, results/div_end out)
// A request sampled at edge E0 steps through WIDTH restoring edges, applies
// the sign fix-up at E0+WIDTH+1 and pulses div_end for the following cycle.
module divide
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    divide_if.slave  bus
);

    localparam int unsigned      CNT_W       = $clog2(WIDTH + 1);
    localparam int unsigned      ITER_CYCLES = WIDTH;
    localparam logic [CNT_W-1:0] LAST_STEP   = CNT_W'(ITER_CYCLES - 1);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    state_t state, next_state;

    logic [WIDTH-1:0] rem_q, dvd_q, dsr_q, op1_raw_q;
    logic             sign_quo_q, sign_rem_q, zero_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q, end_q;

    logic             do_load, do_step, do_fix;
    logic             s1, s2;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next state and datapath strobes; dropping begin in RUN/FIX aborts.
    always_comb begin
        next_state = state;
        do_load    = 1'b0;
        do_step    = 1'b0;
        do_fix     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.div_begin) begin
                    do_load    = 1'b1;
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.div_begin) begin
                    next_state = S_IDLE;
                end else begin
                    do_step = 1'b1;
                    if (cnt_q == LAST_STEP) next_state = S_FIX;
                end
            end
            S_FIX: begin
                if (!bus.div_begin) begin
                    next_state = S_IDLE;
                end else begin
                    do_fix     = 1'b1;
                    next_state = S_DONE;
                end
            end
            S_DONE: next_state = bus.div_begin ? S_HOLD : S_IDLE;
            S_HOLD: if (!bus.div_begin) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Operand magnitudes; signs only matter in signed mode.
    always_comb begin
        s1   = bus.div_signed & bus.div_op1[WIDTH-1];
        s2   = bus.div_signed & bus.div_op2[WIDTH-1];
        abs1 = s1 ? (~bus.div_op1 + ONE) : bus.div_op1;
        abs2 = s2 ? (~bus.div_op2 + ONE) : bus.div_op2;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .bit_in   (dvd_q[WIDTH-1]),
        .divisor  (dsr_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Datapath: dvd_q shifts the dividend out and the quotient in from the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            op1_raw_q   <= '0;
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            zero_q      <= 1'b0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            end_q       <= 1'b0;
        end else begin
            end_q <= do_fix;
            if (do_load) begin
                rem_q      <= '0;
                dvd_q      <= abs1;
                dsr_q      <= abs2;
                op1_raw_q  <= bus.div_op1;
                sign_quo_q <= s1 ^ s2;
                sign_rem_q <= s1;
                zero_q     <= (bus.div_op2 == '0);
                cnt_q      <= '0;
            end
            if (do_step) begin
                rem_q <= step_rem;
                dvd_q <= {dvd_q[WIDTH-2:0], step_q};
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (do_fix) begin
                if (zero_q) begin
                    quotient_q  <= '1;
                    remainder_q <= op1_raw_q;
                    dbz_q       <= 1'b1;
                end else begin
                    // Remainder follows the dividend sign (truncating division).
                    quotient_q  <= sign_quo_q ? (~dvd_q + ONE) : dvd_q;
                    remainder_q <= sign_rem_q ? (~rem_q + ONE) : rem_q;
                    dbz_q       <= 1'b0;
                end
            end
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.div_end     = end_q;

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for the iterative divider: directed vector table,
// abort/reset/hold sequences and a behavioural model for random operands.
module tb_divide;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    divide_if #(.WIDTH(32)) bus ();

    divide #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Independent reference: language / and % operators.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        logic signed [31:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        z  = 1'b0;
        if (b == 32'h0) begin
            q = 32'hFFFFFFFF;
            r = a;
            z = 1'b1;
        end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'h0;
        end else if (s) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issue one request, scramble operands after sampling, wait for div_end.
    // lat counts edges from the sampling edge (inclusive) to the div_end edge.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r, output logic z,
                           output int lat);
        @(negedge clk);
        bus.div_op1    = a;
        bus.div_op2    = b;
        bus.div_signed = s;
        bus.div_begin  = 1'b1;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                bus.div_op1    = ~a;
                bus.div_op2    = b ^ 32'h5A5A5A5A;
                bus.div_signed = ~s;
            end
            if (bus.div_end) break;
        end
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
        bus.div_begin = 1'b0;
        @(posedge clk);
        #1;
        check("end_single_cycle", 32'(bus.div_end), 32'h0);
    endtask

    logic [31:0] q, r, eq, er, last_q, last_r;
    logic        z, ez, last_z;
    int          lat, pulses;

    initial begin
        vecs[0]  = '{32'h01234321, 32'h00001111, 1'b0, 32'h00001111, 32'h00000000, 1'b0};
        vecs[1]  = '{32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{32'hFFFFFFF9, 32'h00000002, 1'b0, 32'h7FFFFFFC, 32'h00000001, 1'b0};
        vecs[3]  = '{32'h12345678, 32'h00000000, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[4]  = '{32'h12345678, 32'h00000000, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h00000000, 1'b0};
        vecs[6]  = '{32'h00000007, 32'h00000009, 1'b0, 32'h00000000, 32'h00000007, 1'b0};
        vecs[7]  = '{32'hFFFFFF9C, 32'h00000007, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        vecs[8]  = '{32'h00000064, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'h00000002, 1'b0};
        vecs[9]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[10] = '{32'h00000000, 32'h00000005, 1'b1, 32'h00000000, 32'h00000000, 1'b0};

        rst            = 1'b1;
        bus.div_begin  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_op1    = '0;
        bus.div_op2    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_quotient", bus.quotient, 32'h0);
        check("reset_remainder", bus.remainder, 32'h0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'h0);
        check("reset_end", 32'(bus.div_end), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            run_div(vecs[i].op1, vecs[i].op2, vecs[i].sgn, q, r, z, lat);
            check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), 32'(z), 32'(vecs[i].z));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd34);
            last_q = vecs[i].q;
            last_r = vecs[i].r;
            last_z = vecs[i].z;
        end

        // Abort at RUN cycle 10: no div_end, outputs untouched.
        @(negedge clk);
        bus.div_op1    = 32'h00000064;
        bus.div_op2    = 32'h00000003;
        bus.div_signed = 1'b0;
        bus.div_begin  = 1'b1;
        pulses = 0;
        repeat (11) begin
            @(posedge clk);
            #1;
            if (bus.div_end) pulses++;
        end
        bus.div_begin = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.div_end) pulses++;
        end
        check("abort_no_end", 32'(pulses), 32'h0);
        check("abort_quotient_kept", bus.quotient, last_q);
        check("abort_remainder_kept", bus.remainder, last_r);
        check("abort_dbz_kept", 32'(bus.div_by_zero), 32'(last_z));
        run_div(32'h00000064, 32'h00000003, 1'b0, q, r, z, lat);
        check("after_abort_quotient", q, 32'd33);
        check("after_abort_remainder", r, 32'd1);
        check("after_abort_latency", 32'(lat), 32'd34);

        // Reset mid-RUN.
        @(negedge clk);
        bus.div_op1    = 32'h00001000;
        bus.div_op2    = 32'h00000010;
        bus.div_signed = 1'b0;
        bus.div_begin  = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.div_end) pulses++;
        end
        rst           = 1'b1;
        bus.div_begin = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.div_end) pulses++;
        end
        check("rst_mid_no_end", 32'(pulses), 32'h0);
        check("rst_mid_quotient", bus.quotient, 32'h0);
        check("rst_mid_remainder", bus.remainder, 32'h0);
        check("rst_mid_dbz", 32'(bus.div_by_zero), 32'h0);
        run_div(32'h00001000, 32'h00000010, 1'b0, q, r, z, lat);
        check("after_rst_quotient", q, 32'h00000100);
        check("after_rst_latency", 32'(lat), 32'd34);

        // Begin held for 40 cycles gives a single result.
        @(negedge clk);
        bus.div_op1    = 32'hFFFFFFF6;
        bus.div_op2    = 32'h00000003;
        bus.div_signed = 1'b1;
        bus.div_begin  = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.div_end) pulses++;
        end
        bus.div_begin = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.div_end) pulses++;
        end
        check("hold_one_pulse", 32'(pulses), 32'd1);
        check("hold_quotient", bus.quotient, 32'hFFFFFFFD);
        check("hold_remainder", bus.remainder, 32'hFFFFFFFF);

        // Random operands against the behavioural model, both modes.
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 10; k++) begin
                logic [31:0] a, b;
                a = $urandom;
                b = $urandom >> $urandom_range(0, 31);
                model(a, b, m[0], eq, er, ez);
                run_div(a, b, m[0], q, r, z, lat);
                check($sformatf("rnd_m%0d_%0d_quotient", m, k), q, eq);
                check($sformatf("rnd_m%0d_%0d_remainder", m, k), r, er);
                check($sformatf("rnd_m%0d_%0d_dbz", m, k), 32'(z), 32'(ez));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divide.md
Name: divide

Overview:
- Iterative 32-bit integer divider; the inverse companion to the team's iterative `multiply` block, and it uses the same level-held begin/end handshake style.
- Restoring algorithm, one quotient bit per clock, then a sign fix-up cycle.
- Serves signed and unsigned DIV/REM in the teaching CPU datapath.
- Fixed latency, independent of operand values.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- div_begin  input  1  level request; held high by requester until div_end seen.
- div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
- div_op1  input  WIDTH  dividend.
- div_op2  input  WIDTH  divisor.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag; valid with results.
- div_end  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; quotient, remainder and div_by_zero = 0; div_end = 0; counter = 0. Reset wins over every other event, including mid-RUN; an aborted run produces no div_end.
- States: IDLE, RUN, FIX, DONE, HOLD.
- IDLE (edge E0, div_begin=1):
  - Latch |op1|, |op2| (abs only when div_signed), sign_q = s1^s2, sign_r = s1, raw op1, op2==0 flag.
  - Clear partial remainder; counter = 0; go to RUN.
- RUN: each edge does one restoring step:
  - Shift {rem, dvd} left 1; trial = rem - divisor (WIDTH+1 bits).
  - If non-negative, rem = trial and quotient bit = 1; else keep rem and bit = 0.
  - Counter increments. After WIDTH steps (edge E0+WIDTH) go to FIX.
- FIX (edge E0+WIDTH+1):
  - Negate quotient if sign_q, negate remainder if sign_r (signed mode only).
  - Write the quotient, remainder and div_by_zero registers; set div_end=1; go to DONE.
- DONE: div_end high for exactly this one cycle.
  - Next edge: go to HOLD if div_begin still 1, else IDLE.
- HOLD: wait for div_begin=0, then IDLE. No restart while begin stays high, so holding begin long gives exactly one result.
- Latency: div_end high during the cycle after edge E0+33 (WIDTH=32).
- Abort: div_begin=0 at any edge in RUN or FIX returns to IDLE. Outputs keep their previous values; no div_end.
- Operand/div_signed changes after E0 are ignored (latched).
- Outputs change only at the FIX edge or on reset; they are held stable otherwise until the next completed division.
- Divide by zero (op2==0):
  - Full latency still applies.
  - FIX overrides results: quotient = all ones, remainder = raw div_op1, div_by_zero = 1, in either mode.
- Signed overflow (0x80000000 / 0xFFFFFFFF, signed): quotient = 0x80000000, remainder = 0, div_by_zero = 0. This falls out of the abs/negate path with no special case.
- Remainder sign always follows the dividend (C truncation semantics): |remainder| < |divisor|.

Decomposition:
- Package div_pkg:
  - State encoding constants.
  - WIDTH default.
  - Counter width clog2(WIDTH+1).
  - ITER_CYCLES = WIDTH.
- One combinational sub-module, div_step:
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
  - Instantiated once in the RUN datapath; makes step-level unit testing easy.

Test Plan:
- Unsigned 0x01234321 / 0x00001111 (inverse of 0x1111*0x1111) -> quotient 0x00001111, remainder 0, div_by_zero 0. div_end is a single pulse 34 edges after begin is sampled.
- 0xFFFFFFF9 / 0x00000002, both modes:
  - div_signed=1 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - div_signed=0 -> quotient 0x7FFFFFFC, remainder 0x00000001.
- 0x12345678 / 0, signed and unsigned -> quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1, same latency.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; also unsigned 7/9 -> quotient 0, remainder 7.
- Abort and reset:
  - Drop div_begin at RUN cycle 10 -> no div_end, outputs unchanged; a following request completes correctly.
  - rst pulse mid-RUN -> outputs 0, IDLE, no div_end.
- Hold and random:
  - Hold div_begin high 40 cycles -> exactly one div_end pulse.
  - 10 $random operand pairs per mode, checked against a behavioural / and % model (signed via $signed).
